// File: rtl/dsp_row_driver.sv
// Command/collect end of a 17x17 DSP MAC column: computes one row
// R = A*b + c, issuing limbs with the DSP's pipeline offsets and streaming
// S+1 17-bit result limbs extracted through the P>>17 carry path.
module dsp_row_driver #(
    parameter int S     = 4,
    parameter int ABREG = 1,
    parameter int MREG  = 1
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [17*S-1:0] A_i,
    input  logic [16:0]     b_i,
    input  logic [16:0]     c_i,
    output logic [16:0]     DSP_A_o,
    output logic [16:0]     DSP_B_o,
    output logic [33:0]     DSP_C_o,
    output logic            DSP_CREG_en_o,
    output logic [6:0]      DSP_OPMODE_o,
    input  logic [33:0]     DSP_P_i,
    output logic            busy_o,
    output logic            res_valid_o,
    output logic [16:0]     res_limb_o,
    output logic            res_last_o,
    output logic            done_o
);

    localparam int DSP_REG_LEVEL = 1 + ABREG + MREG;
    // OPMODE/C trail A/B by this many cycles so they meet the M stage
    localparam int CTRL_DLY = ABREG + MREG - 1;
    localparam int CW = $clog2(S + 1);
    localparam logic [CW-1:0] K_FLUSH = CW'(S);
    localparam logic [6:0] OPM_FIRST = 7'b0110101;  // P = M + C
    localparam logic [6:0] OPM_ACC   = 7'b1100101;  // P = M + P>>17
    localparam logic [6:0] OPM_FLUSH = 7'b1100000;  // P = P>>17

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   k_q, k_nxt;
    logic [17*S-1:0] a_q;
    logic [16:0]     b_q;
    logic            capture, shift_a;
    logic            iss_v, iss_last, iss_creg;
    logic [16:0]     iss_a, iss_b;
    logic [6:0]      iss_opm;
    logic [33:0]     iss_c;
    logic [6:0]      opm_s0, opm_s1;
    logic            creg_s0, creg_s1;
    logic [33:0]     c_s0, c_s1;
    logic [DSP_REG_LEVEL:0] v_pipe, l_pipe;
    logic            unused_p_hi;

    // Upper P bits feed the DSP's own shift path only
    assign unused_p_hi = ^DSP_P_i[33:17];

    // Next-state and the issue to be presented after the coming edge;
    // issue 0 comes straight from the inputs so it appears right after accept
    always_comb begin
        state_nxt = state;
        k_nxt     = k_q;
        capture   = 1'b0;
        shift_a   = 1'b0;
        iss_v     = 1'b0;
        iss_last  = 1'b0;
        iss_creg  = 1'b0;
        iss_a     = '0;
        iss_b     = '0;
        iss_opm   = '0;
        iss_c     = '0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    capture   = 1'b1;
                    state_nxt = ST_ISSUE;
                    k_nxt     = '0;
                    iss_v     = 1'b1;
                    iss_a     = A_i[16:0];
                    iss_b     = b_i;
                    iss_opm   = OPM_FIRST;
                    iss_creg  = 1'b1;
                    iss_c     = {17'b0, c_i};
                end
            end
            ST_ISSUE: begin
                if (k_q == K_FLUSH) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    k_nxt = k_q + CW'(1);
                    iss_v = 1'b1;
                    if (k_nxt == K_FLUSH) begin
                        iss_last = 1'b1;
                        iss_opm  = OPM_FLUSH;
                    end else begin
                        iss_a   = a_q[16:0];
                        iss_b   = b_q;
                        iss_opm = OPM_ACC;
                        shift_a = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (res_last_o) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, issue counter and captured operands; A is kept as a shifting
    // queue of the limbs still to be issued
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state <= ST_IDLE;
            k_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_nxt;
            k_q   <= k_nxt;
            if (capture) begin
                a_q <= {17'b0, A_i[17*S-1:17]};
                b_q <= b_i;
            end else if (shift_a) begin
                a_q <= {17'b0, a_q[17*S-1:17]};
            end
        end
    end

    // Registered A/B plus a two-deep OPMODE/C pipe for the control offset
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            DSP_A_o <= '0;
            DSP_B_o <= '0;
            opm_s0  <= '0;
            opm_s1  <= '0;
            creg_s0 <= 1'b0;
            creg_s1 <= 1'b0;
            c_s0    <= '0;
            c_s1    <= '0;
        end else begin
            DSP_A_o <= iss_a;
            DSP_B_o <= iss_b;
            opm_s0  <= iss_opm;
            opm_s1  <= opm_s0;
            creg_s0 <= iss_creg;
            creg_s1 <= creg_s0;
            c_s0    <= iss_c;
            c_s1    <= c_s0;
        end
    end

    assign DSP_OPMODE_o  = (CTRL_DLY == 0) ? opm_s0  : opm_s1;
    assign DSP_CREG_en_o = (CTRL_DLY == 0) ? creg_s0 : creg_s1;
    assign DSP_C_o       = (CTRL_DLY == 0) ? c_s0    : c_s1;

    // Valid/last tracking of issues through the DSP, then limb collection
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            v_pipe      <= '0;
            l_pipe      <= '0;
            res_valid_o <= 1'b0;
            res_limb_o  <= '0;
            res_last_o  <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            v_pipe      <= {v_pipe[DSP_REG_LEVEL-1:0], iss_v};
            l_pipe      <= {l_pipe[DSP_REG_LEVEL-1:0], iss_last};
            res_valid_o <= v_pipe[DSP_REG_LEVEL];
            res_limb_o  <= v_pipe[DSP_REG_LEVEL] ? DSP_P_i[16:0] : '0;
            res_last_o  <= v_pipe[DSP_REG_LEVEL] & l_pipe[DSP_REG_LEVEL];
            done_o      <= v_pipe[DSP_REG_LEVEL] & l_pipe[DSP_REG_LEVEL];
        end
    end

    assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_dsp_row_driver.sv
// Directed bench: three drivers with (ABREG,MREG) = (1,1), (0,1), (1,0),
// each closing the loop through a behavioural DSP column model.
module tb_dsp_row_driver;
    localparam int S  = 4;
    localparam int NI = 3;
    localparam int NT = 24;

    localparam logic [17*S-1:0]     A1   = {17'd0, 17'd0, 17'd0, 17'd3};
    localparam logic [17*(S+1)-1:0] E1   = {17'd0, 17'd0, 17'd0, 17'd0, 17'h00016};
    localparam logic [17*S-1:0]     AMAX = {4{17'h1FFFF}};
    localparam logic [17*(S+1)-1:0] EMAX = {17'h1FFFF, 17'd0, 17'd0, 17'd0, 17'd0};
    localparam logic [17*S-1:0]     ACAR = {17'h00003, 17'h00002, 17'h00001, 17'h10000};
    localparam logic [17*(S+1)-1:0] ECAR = {17'd0, 17'h0000C, 17'h00008, 17'h00006, 17'h1FFFF};
    localparam logic [17*S-1:0]     ATRC = {17'h04444, 17'h03333, 17'h02222, 17'h11111};

    int checks = 0;
    int errors = 0;
    int lvl_c[NI] = '{3, 2, 2};   // DSP_REG_LEVEL per instance
    int dly_c[NI] = '{1, 0, 0};   // ABREG+MREG-1 per instance

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [17*S-1:0] a_in = '0;
    logic [16:0]     b_in = '0;
    logic [16:0]     c_in = '0;

    logic [16:0] dsp_a [NI];
    logic [16:0] dsp_b [NI];
    logic [33:0] dsp_c [NI];
    logic        creg  [NI];
    logic [6:0]  dsp_opm [NI];
    logic [33:0] dsp_p [NI];
    logic        busy  [NI];
    logic        res_valid [NI];
    logic [16:0] res_limb [NI];
    logic        res_last [NI];
    logic        done  [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_col
        localparam int AB = (g == 1) ? 0 : 1;
        localparam int MR = (g == 2) ? 0 : 1;

        dsp_row_driver #(.S(S), .ABREG(AB), .MREG(MR)) u_dut (
            .clock_i(clk), .reset_i(rst), .start_i(start),
            .A_i(a_in), .b_i(b_in), .c_i(c_in),
            .DSP_A_o(dsp_a[g]), .DSP_B_o(dsp_b[g]), .DSP_C_o(dsp_c[g]),
            .DSP_CREG_en_o(creg[g]), .DSP_OPMODE_o(dsp_opm[g]), .DSP_P_i(dsp_p[g]),
            .busy_o(busy[g]), .res_valid_o(res_valid[g]), .res_limb_o(res_limb[g]),
            .res_last_o(res_last[g]), .done_o(done[g])
        );

        // Behavioural DSP column: optional A/B and M registers, OPMODE and
        // C registers, P register; X/Y = M when OPMODE[3:0]=0101
        logic [16:0] a1 = '0, b1 = '0;
        logic [33:0] m_r = '0, c_r = '0, p_r = '0;
        logic [6:0]  opm_r = '0;
        logic [16:0] a_eff, b_eff;
        logic [33:0] m_now, m_eff, xy_t, z_t;

        always_comb begin
            a_eff = (AB != 0) ? a1 : dsp_a[g];
            b_eff = (AB != 0) ? b1 : dsp_b[g];
            m_now = {17'b0, a_eff} * {17'b0, b_eff};
            m_eff = (MR != 0) ? m_r : m_now;
            xy_t  = (opm_r[3:0] == 4'b0101) ? m_eff : '0;
            case (opm_r[6:4])
                3'b011:  z_t = c_r;
                3'b110:  z_t = p_r >> 17;
                default: z_t = '0;
            endcase
        end

        always @(posedge clk) begin
            a1    <= dsp_a[g];
            b1    <= dsp_b[g];
            m_r   <= m_now;
            opm_r <= dsp_opm[g];
            if (creg[g]) c_r <= dsp_c[g];
            p_r   <= xy_t + z_t;
        end

        assign dsp_p[g] = p_r;
    end

    // Per-row observations, indexed by cycle relative to I0
    logic [16:0] got_limb [NI][12];
    int          got_n [NI];
    int          first_rel [NI], second_rel [NI], last_rel [NI], done_rel [NI];
    int          busy_low_rel [NI], busy_again_rel [NI];
    logic [6:0]  opm_tr [NI][NT];
    logic        creg_tr [NI][NT];
    logic [33:0] c_tr [NI][NT];
    logic [16:0] a_tr [NI][NT];
    logic [16:0] b_tr [NI][NT];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one accept edge; returns in cycle I0
    task automatic start_row(input logic [17*S-1:0] a, input logic [16:0] b, input logic [16:0] c);
        a_in  = a;
        b_in  = b;
        c_in  = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic collect(input int ncyc, input int chg_rel, input logic [17*S-1:0] a2,
                           input logic [16:0] b2, input logic [16:0] c2);
        for (int i = 0; i < NI; i++) begin
            got_n[i] = 0; first_rel[i] = -1; second_rel[i] = -1; last_rel[i] = -1;
            done_rel[i] = -1; busy_low_rel[i] = -1; busy_again_rel[i] = -1;
        end
        for (int r = 0; r < ncyc; r++) begin
            if (r == chg_rel) begin
                a_in = a2; b_in = b2; c_in = c2;
            end
            for (int i = 0; i < NI; i++) begin
                if (r < NT) begin
                    opm_tr[i][r] = dsp_opm[i]; creg_tr[i][r] = creg[i]; c_tr[i][r] = dsp_c[i];
                    a_tr[i][r] = dsp_a[i]; b_tr[i][r] = dsp_b[i];
                end
                if (res_valid[i]) begin
                    if (first_rel[i] < 0) first_rel[i] = r;
                    if (got_n[i] == S + 1) second_rel[i] = r;
                    if (got_n[i] < 12) got_limb[i][got_n[i]] = res_limb[i];
                    got_n[i]++;
                end
                if (res_last[i] && last_rel[i] < 0) last_rel[i] = r;
                if (done[i] && done_rel[i] < 0) done_rel[i] = r;
                if (!busy[i] && busy_low_rel[i] < 0) busy_low_rel[i] = r;
                if (busy[i] && busy_low_rel[i] >= 0 && busy_again_rel[i] < 0) busy_again_rel[i] = r;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({dsp_a[i], dsp_b[i], dsp_c[i], creg[i], dsp_opm[i]} !== '0) begin
                errors++;
                $display("FAIL reset_dsp inst%0d: got A=%h B=%h C=%h en=%b opm=%h, required all 0",
                         i, dsp_a[i], dsp_b[i], dsp_c[i], creg[i], dsp_opm[i]);
            end
            checks++;
            if ({busy[i], res_valid[i], res_limb[i], res_last[i], done[i]} !== '0) begin
                errors++;
                $display("FAIL reset_status inst%0d: got busy=%b v=%b limb=%h last=%b done=%b, required all 0",
                         i, busy[i], res_valid[i], res_limb[i], res_last[i], done[i]);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_row(input string name, input logic [17*S-1:0] a, input logic [16:0] b,
                            input logic [16:0] c, input logic [17*(S+1)-1:0] e);
        logic [16:0] exp_l;
        start_row(a, b, c);
        collect(20, -1, '0, '0, '0);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (got_n[i] != S + 1) begin
                errors++;
                $display("FAIL %s_count inst%0d: got %0d limbs, required %0d", name, i, got_n[i], S + 1);
            end
            for (int k = 0; k <= S; k++) begin
                exp_l = e[17*k +: 17];
                checks++;
                if (got_limb[i][k] !== exp_l) begin
                    errors++;
                    $display("FAIL %s_limb inst%0d k%0d: got %h, required %h", name, i, k, got_limb[i][k], exp_l);
                end
            end
            checks++;
            if (first_rel[i] != lvl_c[i] + 1) begin
                errors++;
                $display("FAIL %s_first inst%0d: limb0 at I0+%0d, required I0+%0d", name, i, first_rel[i], lvl_c[i] + 1);
            end
            checks++;
            if (last_rel[i] != S + lvl_c[i] + 1 || done_rel[i] != S + lvl_c[i] + 1) begin
                errors++;
                $display("FAIL %s_last inst%0d: last at I0+%0d done at I0+%0d, required I0+%0d",
                         name, i, last_rel[i], done_rel[i], S + lvl_c[i] + 1);
            end
            checks++;
            if (busy_low_rel[i] != S + lvl_c[i] + 2) begin
                errors++;
                $display("FAIL %s_busy inst%0d: busy low at I0+%0d, required I0+%0d", name, i, busy_low_rel[i], S + lvl_c[i] + 2);
            end
        end
    endtask

    task automatic test_opmode_trace();
        logic [6:0]  e_opm;
        logic [16:0] e_a, e_b;
        logic [17*S-1:0] av;
        int d, ncreg;
        av = ATRC;
        start_row(ATRC, 17'h00055, 17'h00077);
        collect(20, -1, '0, '0, '0);
        for (int i = 0; i < NI; i++) begin
            d = dly_c[i];
            ncreg = 0;
            for (int r = 0; r < 20; r++) begin
                if (r == d) e_opm = 7'h35;
                else if (r > d && r < d + S) e_opm = 7'h65;
                else if (r == d + S) e_opm = 7'h60;
                else e_opm = 7'h00;
                e_a = (r < S) ? av[17*r +: 17] : 17'd0;
                e_b = (r < S) ? 17'h00055 : 17'd0;
                if (creg_tr[i][r]) ncreg++;
                checks++;
                if (opm_tr[i][r] !== e_opm || creg_tr[i][r] !== (r == d)) begin
                    errors++;
                    $display("FAIL trace_ctrl inst%0d I0+%0d: got opm=%h en=%b, required opm=%h en=%b",
                             i, r, opm_tr[i][r], creg_tr[i][r], e_opm, (r == d));
                end
                checks++;
                if (a_tr[i][r] !== e_a || b_tr[i][r] !== e_b) begin
                    errors++;
                    $display("FAIL trace_ab inst%0d I0+%0d: got A=%h B=%h, required A=%h B=%h",
                             i, r, a_tr[i][r], b_tr[i][r], e_a, e_b);
                end
            end
            checks++;
            if (ncreg != 1 || c_tr[i][d] !== 34'h0_0000_0077) begin
                errors++;
                $display("FAIL trace_c inst%0d: got %0d enables, C=%h, required 1 enable with C=%h",
                         i, ncreg, c_tr[i][d], 34'h0_0000_0077);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp_l;
        int per;
        a_in = A1; b_in = 17'd5; c_in = 17'd7;
        start = 1'b1;
        tick();
        collect(20, 2, AMAX, 17'h1FFFF, 17'h1FFFF);
        for (int i = 0; i < NI; i++) begin
            per = S + lvl_c[i] + 3;
            checks++;
            if (busy_low_rel[i] != per - 1 || busy_again_rel[i] != per) begin
                errors++;
                $display("FAIL b2b_busy inst%0d: low at I0+%0d high at I0+%0d, required %0d and %0d",
                         i, busy_low_rel[i], busy_again_rel[i], per - 1, per);
            end
            checks++;
            if (got_n[i] != 2 * (S + 1) || second_rel[i] != per + lvl_c[i] + 1) begin
                errors++;
                $display("FAIL b2b_rows inst%0d: got %0d limbs, row2 at I0+%0d, required %0d limbs at I0+%0d",
                         i, got_n[i], second_rel[i], 2 * (S + 1), per + lvl_c[i] + 1);
            end
            for (int k = 0; k < 2 * (S + 1); k++) begin
                exp_l = (k <= S) ? E1[17*k +: 17] : EMAX[17*(k-S-1) +: 17];
                checks++;
                if (got_limb[i][k] !== exp_l) begin
                    errors++;
                    $display("FAIL b2b_limb inst%0d n%0d: got %h, required %h", i, k, got_limb[i][k], exp_l);
                end
            end
        end
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int nv [NI];
        start_row(A1, 17'd5, 17'd7);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({dsp_a[i], dsp_b[i], dsp_c[i], creg[i], dsp_opm[i], busy[i],
                 res_valid[i], res_limb[i], res_last[i], done[i]} !== '0) begin
                errors++;
                $display("FAIL midreset_out inst%0d: got A=%h opm=%h busy=%b v=%b limb=%h, required all 0",
                         i, dsp_a[i], dsp_opm[i], busy[i], res_valid[i], res_limb[i]);
            end
            nv[i] = 0;
        end
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < NI; i++) if (res_valid[i] || busy[i]) nv[i]++;
            tick();
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (nv[i] != 0) begin
                errors++;
                $display("FAIL midreset_quiet inst%0d: got %0d valid/busy cycles, required 0", i, nv[i]);
            end
        end
        test_row("after_reset", A1, 17'd5, 17'd7, E1);
    endtask

    initial begin
        test_reset();
        test_row("basic", A1, 17'd5, 17'd7, E1);
        test_row("max", AMAX, 17'h1FFFF, 17'h1FFFF, EMAX);
        test_row("carry", ACAR, 17'd4, 17'h1FFFF, ECAR);
        test_opmode_trace();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, required completion before 200000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dsp_row_driver.md
# dsp_row_driver

Sequencer that drives one 17×17 DSP multiply-accumulate column (17-bit A/B, 34-bit C, 7-bit OPMODE, registered C enable, 34-bit P) to compute one FIOS row product R = A·b + c.

- A is an S-limb operand; b and c are single 17-bit limbs.
- The block issues operands, OPMODE and C to the DSP with the correct pipeline offsets.
- It collects P, extracts 17-bit result limbs using the DSP's P>>17 carry path, and streams S+1 result limbs to the datapath.
- It is the command/collect end of the DSP column interface.

## Interface
Parameters:
- S, 4: number of 17-bit limbs in A (S ≥ 2)
- ABREG, 1: A/B input register depth of the driven DSP (0 or 1)
- MREG, 1: multiplier register depth of the driven DSP (0 or 1); ABREG+MREG ≥ 1 required
- Derived DSP_REG_LEVEL = 1+ABREG+MREG: A/B issue to P-visible latency

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clock_i  in  1  clock
  - reset_i  in  1  synchronous active-high reset
- Command and operands:
  - start_i  in  1  start request, accepted only when busy_o=0
  - A_i  in  17*S  operand A, limb k at [17k+16:17k], captured on accept
  - b_i  in  17  scalar limb b, captured on accept
  - c_i  in  17  addend c, captured on accept
- DSP column interface:
  - DSP_A_o  out  17  multiplier input A
  - DSP_B_o  out  17  multiplier input B
  - DSP_C_o  out  34  C input, {17'b0, c}
  - DSP_CREG_en_o  out  1  C register enable
  - DSP_OPMODE_o  out  7  DSP OPMODE
  - DSP_P_i  in  34  DSP P[33:0]
- Status and result stream:
  - busy_o  out  1  high from accept until the cycle after the last limb
  - res_valid_o  out  1  result limb valid
  - res_limb_o  out  17  result limb, order k = 0..S
  - res_last_o  out  1  marks limb S
  - done_o  out  1  one-cycle pulse, coincident with res_last_o

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - start_i=1 at a clock edge captures A_i, b_i, c_i, sets busy_o and moves to ISSUE.
  - The first issue cycle I0 is the cycle after that edge.
- ISSUE: S+1 issue cycles, k = 0..S; all DSP outputs are registered.
  - k=0: DSP_A_o=A[0], DSP_B_o=b; OPMODE 7'b0110101 (P = M + C).
  - 1 ≤ k ≤ S-1: DSP_A_o=A[k], DSP_B_o=b; OPMODE 7'b1100101 (P = M + P>>17).
  - k=S (flush): DSP_A_o=0, DSP_B_o=0; OPMODE 7'b1100000 (P = P>>17).
- Pipeline alignment:
  - OPMODE and C for issue k are driven ABREG+MREG-1 cycles after that issue's A/B. The OPMODE register then lines up with the M stage.
  - DSP_C_o={17'b0,c} with DSP_CREG_en_o=1 is driven only in the C/OPMODE cycle of issue k=0. DSP_CREG_en_o=0 otherwise.
  - Between issues, and outside ISSUE, DSP_OPMODE_o=0 and DSP_A_o=DSP_B_o=0.
- Collection:
  - A valid shift register of DSP_REG_LEVEL+1 stages tracks issues.
  - res_limb_o is registered from DSP_P_i[16:0] sampled DSP_REG_LEVEL cycles after issue k.
- Arithmetic:
  - c < 2^17, so R < 2^(17(S+1)). R fits exactly in S+1 limbs and the flush P never exceeds 17 bits.
  - DSP_P_i[33:17] is not otherwise used by the block.
- DRAIN: entered after the flush issue. After res_last_o, return to IDLE; busy_o drops the following cycle.
- start_i while busy_o=1 is ignored and has no effect on the current row.
- Reset (synchronous, any state):
  - Returns to IDLE and clears the valid pipe, so in-flight DSP results are never emitted.
  - Every output resets to 0; OPMODE resets to 7'b0000000.

## Timing
- Issue k occupies cycle I0+k.
- OPMODE/C for issue k are driven in cycle I0+k+ABREG+MREG-1.
- res_valid_o for limb k is high in cycle I0+k+DSP_REG_LEVEL+1.
- Limbs are emitted in S+1 consecutive cycles, with no gaps.
- Defaults (S=4, DSP_REG_LEVEL=3): limb 0 at I0+4, limb 4 with res_last_o/done_o at I0+8; busy_o low from I0+9.
- A new start_i is accepted in the first cycle busy_o=0.
- Throughput: one row per S+DSP_REG_LEVEL+3 cycles.

## Test plan
- A limbs (0..3) = {3,0,0,0}, b=5, c=7 → limbs {0x00016,0,0,0,0}. Limb 0 appears at I0+4 and done_o at I0+8.
- All A limbs 0x1FFFF, b=0x1FFFF, c=0x1FFFF (R = 2^85−2^68) → limbs {0,0,0,0,0x1FFFF}.
- start_i held high throughout a row → exactly one row produced, and a second row starts the cycle busy_o falls. Captured operands are unaffected by A_i changes mid-row.
- reset_i asserted at I0+5 → all outputs 0 the next cycle, no further res_valid_o, and the block returns to IDLE. A following start produces a correct row.
- OPMODE/CREG_en trace check: CREG_en exactly one cycle per row. OPMODE sequence is 0x35, 0x65, 0x65, 0x65, 0x60, offset ABREG+MREG-1 from A/B.
- Repeat the first two scenarios with (ABREG,MREG) = (0,1), (1,0), (1,1) against a behavioral DSP model → identical limbs, with latency tracking DSP_REG_LEVEL.
